max7219_daisy_tx: RTL and testbench

- Serial transmitter driving a daisy chain of G_NB_MATRIX MAX7219 8x8 matrix controllers over the MAX7219 3-wire interface (CLK/DIN/LOAD).
- Accepts one 16-bit frame per matrix in parallel, shifts the whole chain MSB-first, then pulses LOAD to latch every device at once.
- Sits between the display-control logic (scroll/char engines) and the board pins.
- In simulation, its outputs connect directly to the chained MAX7219 checker model.

---
 rtl/max7219_daisy_tx.sv | 165 ++++++++++++++++
 tb/tb_max7219_daisy_tx.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/max7219_daisy_tx.sv
// Serial transmitter for a daisy chain of MAX7219 matrix drivers (CLK/DIN/LOAD).
// Optional MAX7219_TX_BROADCAST_EN replicates one frame into every chain slot.
module max7219_daisy_tx #(
  parameter int G_NB_MATRIX = 8,
  parameter int G_CLK_DIV   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_start,
  input  logic [16*G_NB_MATRIX-1:0] i_data,
`ifdef MAX7219_TX_BROADCAST_EN
  input  logic                      i_broadcast,
  input  logic [15:0]               i_bcast_frame,
`endif
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_max7219_clk,
  output logic                      o_max7219_din,
  output logic                      o_max7219_load
);

  localparam int W  = 16 * G_NB_MATRIX;
  localparam int BW = $clog2(W);
  localparam int DW = $clog2(G_CLK_DIV) + 1;

  localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);
  localparam logic [DW-1:0] DIV_END  = DW'(G_CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    HOLD,
    LATCH
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    shreg_q, shreg_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DW-1:0]   div_q, div_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            sclk_q, sclk_d;
  logic            din_q, din_d;
  logic            load_q, load_d;
  logic [W-1:0]    load_word;
  logic            div_end;

`ifdef MAX7219_TX_BROADCAST_EN
  assign load_word = i_broadcast ? {G_NB_MATRIX{i_bcast_frame}} : i_data;
`else
  assign load_word = i_data;
`endif

  assign div_end = (div_q == DIV_END);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    div_d   = div_q;
    busy_d  = busy_q;
    done_d  = done_q;
    sclk_d  = sclk_q;
    din_d   = din_q;
    load_d  = load_q;
    unique case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (i_start) begin
          shreg_d = load_word;
          bit_d   = '0;
          div_d   = '0;
          state_d = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        // First cycle after acceptance only raises busy and presents bit 0
        if (!busy_q) begin
          busy_d = 1'b1;
          load_d = 1'b0;
          sclk_d = 1'b0;
          din_d  = shreg_q[W-1];
        end else if (div_end) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          state_d = SHIFT_HI;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      SHIFT_HI: begin
        if (div_end) begin
          div_d  = '0;
          sclk_d = 1'b0;
          if (bit_q == LAST_BIT) begin
            din_d   = 1'b0;
            state_d = HOLD;
          end else begin
            shreg_d = {shreg_q[W-2:0], 1'b0};
            bit_d   = bit_q + BW'(1);
            din_d   = shreg_q[W-2];
            state_d = SHIFT_LO;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      HOLD: begin
        if (div_end) begin
          div_d   = '0;
          load_d  = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = LATCH;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      LATCH: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        sclk_d  = 1'b0;
        din_d   = 1'b0;
        load_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      din_q   <= 1'b0;
      load_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      din_q   <= din_d;
      load_q  <= load_d;
    end
  end

  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_max7219_clk  = sclk_q;
  assign o_max7219_din  = din_q;
  assign o_max7219_load = load_q;

endmodule

// File: tb/tb_max7219_daisy_tx.sv
// Scoreboard bench for max7219_daisy_tx: chain model on the pins vs. frames issued.
// Build with MAX7219_TX_BROADCAST_EN to also exercise broadcast.
`timescale 1ns/1ps
module tb_max7219_daisy_tx;

  localparam int N  = 8;
  localparam int D  = 4;
  localparam int W  = 16 * N;
  localparam int TD = 1 + 32 * N * D + D;

  typedef logic [N-1:0][15:0] frames_t;
  typedef struct {
    frames_t fr;
    int      cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_start = 1'b0;
  logic [W-1:0] i_data = '0;
  logic i_broadcast = 1'b0;
  logic [15:0] i_bcast_frame = '0;
  logic o_busy, o_done, o_sclk, o_din, o_load;

  logic s1_start = 1'b0;
  logic [15:0] s1_data = '0;
  logic s1_busy, s1_done, s1_sclk, s1_din, s1_load;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  max7219_daisy_tx #(.G_NB_MATRIX(N), .G_CLK_DIV(D)) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_start(i_start),
    .i_data(i_data),
`ifdef MAX7219_TX_BROADCAST_EN
    .i_broadcast(i_broadcast),
    .i_bcast_frame(i_bcast_frame),
`endif
    .o_busy(o_busy),
    .o_done(o_done),
    .o_max7219_clk(o_sclk),
    .o_max7219_din(o_din),
    .o_max7219_load(o_load)
  );

  max7219_daisy_tx #(.G_NB_MATRIX(1), .G_CLK_DIV(4)) u_one (
    .clk(clk),
    .rst_n(rst_n),
    .i_start(s1_start),
    .i_data(s1_data),
`ifdef MAX7219_TX_BROADCAST_EN
    .i_broadcast(1'b0),
    .i_bcast_frame(16'h0000),
`endif
    .o_busy(s1_busy),
    .o_done(s1_done),
    .o_max7219_clk(s1_sclk),
    .o_max7219_din(s1_din),
    .o_max7219_load(s1_load)
  );

  // Monitor: behaves as the chained devices, checks pins and pops the scoreboard
  logic [W-1:0] chain = '0;
  logic [15:0] first = '0;
  int nbits = 0;
  int last_chg = -1000;
  logic sclk_p = 1'b0, din_p = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      nbits = 0;
    end else begin
      if (o_din !== din_p) begin
        n_cmp++;
        if (o_sclk !== 1'b0) begin
          n_bad++;
          $display("FAIL din_change_hi cyc=%0d sclk=%b want 0", cyc, o_sclk);
        end
        last_chg = cyc;
      end
      if (o_sclk && !sclk_p) begin
        n_cmp++;
        if (cyc - last_chg < D || o_busy !== 1'b1 || o_load !== 1'b0) begin
          n_bad++;
          $display("FAIL setup cyc=%0d setup=%0d busy=%b load=%b want >=%0d/1/0",
                   cyc, cyc - last_chg, o_busy, o_load, D);
        end
        chain = {chain[W-2:0], o_din};
        nbits++;
        if (nbits == 16) first = chain[15:0];
      end
      if (o_done) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_done cyc=%0d got done=1 want none", cyc);
        end else begin
          e = sb.pop_front();
          n_cmp += 4;
          if (cyc != e.cyc) begin
            n_bad++;
            $display("FAIL done_cycle got %0d want %0d", cyc, e.cyc);
          end
          if (nbits != W) begin
            n_bad++;
            $display("FAIL rise_count got %0d want %0d", nbits, W);
          end
          if (first !== e.fr[N-1]) begin
            n_bad++;
            $display("FAIL first_frame got %h want %h", first, e.fr[N-1]);
          end
          if (o_load !== 1'b1 || o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL done_flags load=%b busy=%b want 1/0", o_load, o_busy);
          end
          for (int k = 0; k < N; k++) begin
            n_cmp++;
            if (chain[16*k +: 16] !== e.fr[k]) begin
              n_bad++;
              $display("FAIL dev%0d_frame got %h want %h", k, chain[16*k +: 16], e.fr[k]);
            end
          end
        end
        nbits = 0;
      end
    end
    sclk_p = o_sclk;
    din_p = o_din;
  end

  function automatic exp_t model(input frames_t fr, input bit bc, input logic [15:0] bf,
                                 input int start_cyc);
    exp_t e;
    for (int k = 0; k < N; k++) e.fr[k] = bc ? bf : fr[k];
    e.cyc = start_cyc + TD;
    return e;
  endfunction

  task automatic xfer(input frames_t fr, input bit bc, input logic [15:0] bf, input bit push);
    @(negedge clk);
    i_data = fr;
    i_broadcast = bc;
    i_bcast_frame = bf;
    i_start = 1'b1;
    if (push) sb.push_back(model(fr, bc, bf, cyc + 1));
    @(negedge clk);
    i_start = 1'b0;
    i_broadcast = 1'b0;
  endtask

  task automatic wait_empty();
    int t = 0;
    while (sb.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout pending=%0d want 0", sb.size());
      sb.delete();
    end
    repeat (5) @(negedge clk);
  endtask

  function automatic frames_t rnd_frames();
    frames_t f;
    for (int k = 0; k < N; k++) f[k] = 16'($urandom);
    return f;
  endfunction

  initial begin
    frames_t f;
    logic [15:0] bits;
    logic [7:0] shut;
    int nr, dcyc, e0, t;
    logic sp;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({o_load, o_sclk, o_din, o_busy, o_done} !== 5'b10000 ||
          {s1_load, s1_sclk, s1_din, s1_busy, s1_done} !== 5'b10000) begin
        n_bad++;
        $display("FAIL reset_idle cyc=%0d got %b/%b want 10000",
                 cyc, {o_load, o_sclk, o_din, o_busy, o_done},
                 {s1_load, s1_sclk, s1_din, s1_busy, s1_done});
      end
    end

    // Single-matrix instance
    @(negedge clk);
    e0 = cyc + 1;
    s1_data = 16'h0C01;
    s1_start = 1'b1;
    @(negedge clk);
    s1_start = 1'b0;
    bits = '0; nr = 0; dcyc = -1; sp = 1'b0; shut = 8'hFF;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s1_sclk && !sp) begin
        bits = {bits[14:0], s1_din};
        nr++;
      end
      sp = s1_sclk;
      if (s1_done && dcyc < 0) begin
        dcyc = cyc - e0;
        if (bits[11:8] == 4'hC) shut = bits[7:0];
      end
    end
    n_cmp += 4;
    if (nr != 16) begin n_bad++; $display("FAIL n1_rises got %0d want 16", nr); end
    if (bits !== 16'h0C01) begin n_bad++; $display("FAIL n1_bits got %h want 0c01", bits); end
    if (dcyc != 133) begin n_bad++; $display("FAIL n1_done_cycle got %0d want 133", dcyc); end
    if (shut !== 8'h01) begin n_bad++; $display("FAIL n1_shutdown got %h want 01", shut); end

    // Full chain: addr 0x01, data 0x10+k
    for (int k = 0; k < N; k++) f[k] = 16'h0110 + 16'(k);
    xfer(f, 1'b0, 16'h0, 1'b1);
    wait_empty();

    // Start and data change while busy are ignored
    xfer(rnd_frames(), 1'b0, 16'h0, 1'b1);
    repeat (197) @(negedge clk);
    i_start = 1'b1;
    i_data = $urandom;
    @(negedge clk);
    i_start = 1'b0;
    i_data = rnd_frames();
    wait_empty();
    repeat (1100) @(negedge clk);

    // Reset at bit 40
    xfer(rnd_frames(), 1'b0, 16'h0, 1'b0);
    t = 0;
    while (nbits < 40 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (o_load !== 1'b1 || o_sclk !== 1'b0 || o_din !== 1'b0 || o_busy !== 1'b0 || t >= 2000) begin
      n_bad++;
      $display("FAIL async_reset load=%b sclk=%b din=%b busy=%b t=%0d want 1/0/0/0",
               o_load, o_sclk, o_din, o_busy, t);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    xfer(rnd_frames(), 1'b0, 16'h0, 1'b1);
    wait_empty();

    // Start held high: back-to-back transfers two cycles after done
    f = rnd_frames();
    @(negedge clk);
    i_data = f;
    i_start = 1'b1;
    e0 = cyc + 1;
    sb.push_back(model(f, 1'b0, 16'h0, e0));
    sb.push_back(model(f, 1'b0, 16'h0, e0 + TD + 2));
    repeat (TD + 3) @(negedge clk);
    i_start = 1'b0;
    wait_empty();

    for (int r = 0; r < 6; r++) begin
      xfer(rnd_frames(), 1'b0, 16'h0, 1'b1);
      wait_empty();
    end

`ifdef MAX7219_TX_BROADCAST_EN
    xfer(rnd_frames(), 1'b1, 16'h0A0F, 1'b1);
    wait_empty();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
